load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 24 ++
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared load/store types: FSM state encoding, word/byte geometry and a big-endian byte picker.
package load_store_unit_pkg;

   localparam int unsigned WordW    = 24;
   localparam int unsigned ByteW    = 8;
   localparam int unsigned NumBytes = 3;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StXfer = 2'd1,
      StResp = 2'd2
   } lsu_state_e;

   // Index 0 is the most significant byte of the word.
   function automatic logic [ByteW-1:0] get_byte(input logic [WordW-1:0] word,
                                                 input logic [1:0]       idx);
      case (idx)
         2'd0:    return word[23:16];
         2'd1:    return word[15:8];
         default: return word[7:0];
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit.sv
// Serialises 24-bit big-endian loads/stores onto a byte-wide memory port,
// with a range check against MEM_BYTES and a one-cycle completion pulse.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 128
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic             ReqWrite,
   input  logic [WordW-1:0] ReqAddress,
   input  logic [WordW-1:0] ReqWriteData,
   output logic             RespValid,
   output logic [WordW-1:0] RespReadData,
   output logic             RespError,
   output logic [WordW-1:0] MemAddress,
   output logic [ByteW-1:0] MemWriteData,
   output logic             MemWrite,
   output logic             MemRead,
   input  logic [ByteW-1:0] MemReadData
);

   lsu_state_e       state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic             write_q, write_d;
   logic             err_q, err_d;
   logic [WordW-1:0] addr_q, addr_d;
   logic [WordW-1:0] wdata_q, wdata_d;
   logic [WordW-1:0] rdata_q, rdata_d;
   logic             in_range;

   // 25-bit sum so addresses near the top of the 24-bit space cannot wrap into range.
   assign in_range = ({1'b0, ReqAddress} + 25'(NumBytes)) <= 25'(MEM_BYTES);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      write_d = write_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         StIdle: begin
            if (ReqValid) begin
               write_d = ReqWrite;
               addr_d  = ReqAddress;
               wdata_d = ReqWriteData;
               idx_d   = 2'd0;
               err_d   = !in_range;
               state_d = in_range ? StXfer : StResp;
               if (!in_range && !ReqWrite) begin
                  rdata_d = '0;
               end
            end
         end
         StXfer: begin
            if (!write_q) begin
               case (idx_q)
                  2'd0:    rdata_d[23:16] = MemReadData;
                  2'd1:    rdata_d[15:8]  = MemReadData;
                  default: rdata_d[7:0]   = MemReadData;
               endcase
            end
            if (idx_q == 2'(NumBytes - 1)) begin
               state_d = StResp;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      ReqReady     = (state_q == StIdle);
      RespValid    = (state_q == StResp);
      RespError    = RespValid && err_q;
      // Stores and rejected accesses report zero data; otherwise the last load is held.
      RespReadData = (RespValid && (write_q || err_q)) ? '0 : rdata_q;
      MemAddress   = '0;
      MemWriteData = '0;
      MemWrite     = 1'b0;
      MemRead      = 1'b0;
      if (state_q == StXfer) begin
         MemAddress   = addr_q + {22'b0, idx_q};
         MemWrite     = write_q;
         MemRead      = !write_q;
         MemWriteData = write_q ? get_byte(wdata_q, idx_q) : '0;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of accesses against a byte memory
// model, plus hand-written reset-abort and back-to-back sequences.
module tb_load_store_unit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [23:0] ReqAddress;
   logic [23:0] ReqWriteData;
   logic        RespValid;
   logic [23:0] RespReadData;
   logic        RespError;
   logic [23:0] MemAddress;
   logic [7:0]  MemWriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [7:0]  MemReadData;

   logic [7:0]  mem [0:127];

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 Clock = ~Clock;

   load_store_unit #(.MEM_BYTES(128)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .ReqValid     (ReqValid),
      .ReqReady     (ReqReady),
      .ReqWrite     (ReqWrite),
      .ReqAddress   (ReqAddress),
      .ReqWriteData (ReqWriteData),
      .RespValid    (RespValid),
      .RespReadData (RespReadData),
      .RespError    (RespError),
      .MemAddress   (MemAddress),
      .MemWriteData (MemWriteData),
      .MemWrite     (MemWrite),
      .MemRead      (MemRead),
      .MemReadData  (MemReadData)
   );

   always @(posedge Clock) begin
      if (MemWrite && MemAddress < 24'd128) mem[MemAddress[6:0]] <= MemWriteData;
   end

   always_comb begin
      MemReadData = 8'h00;
      if (MemAddress < 24'd128) MemReadData = mem[MemAddress[6:0]];
   end

   typedef struct {
      logic        write;
      logic [23:0] addr;
      logic [23:0] wdata;
      logic        err;
      logic [23:0] rdata;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v);
      int          cyc;
      int          nstb;
      logic        got;
      logic [7:0]  exp_byte;
      @(negedge Clock);
      chk("req_ready_idle", 32'(ReqReady), 32'd1);
      ReqValid     = 1'b1;
      ReqWrite     = v.write;
      ReqAddress   = v.addr;
      ReqWriteData = v.wdata;
      @(posedge Clock);
      #1 ReqValid = 1'b0;
      cyc  = 0;
      nstb = 0;
      got  = 1'b0;
      while (!got && cyc < 8) begin
         @(negedge Clock);
         cyc++;
         if (RespValid) begin
            got = 1'b1;
            chk("resp_latency", 32'(cyc), 32'(v.lat));
            chk("resp_error", 32'(RespError), 32'(v.err));
            chk("resp_rdata", 32'(RespReadData), 32'(v.rdata));
            chk("strobe_count", 32'(nstb), v.err ? 32'd0 : 32'd3);
            chk("no_strobe_in_resp", 32'({MemWrite, MemRead}), 32'd0);
         end else if (MemWrite || MemRead) begin
            exp_byte = 8'(v.wdata >> (8 * (2 - nstb)));
            chk("mem_addr", 32'(MemAddress), 32'(v.addr + 24'(nstb)));
            chk("mem_write", 32'(MemWrite), 32'(v.write));
            chk("mem_read", 32'(MemRead), 32'(!v.write));
            if (v.write) chk("mem_wdata", 32'(MemWriteData), 32'(exp_byte));
            nstb++;
         end
      end
      chk("resp_seen", 32'(got), 32'd1);
      @(negedge Clock);
      chk("resp_one_cycle", 32'(RespValid), 32'd0);
      chk("ready_after_resp", 32'(ReqReady), 32'd1);
      if (!v.write && !v.err) chk("rdata_hold", 32'(RespReadData), 32'(v.rdata));
   endtask

   initial begin
      int rv_seen;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      Reset        = 1'b1;
      ReqValid     = 1'b0;
      ReqWrite     = 1'b0;
      ReqAddress   = '0;
      ReqWriteData = '0;

      vecs[0] = '{write: 1'b1, addr: 24'd10,      wdata: 24'hA1B2C3, err: 1'b0, rdata: 24'h0,      lat: 4};
      vecs[1] = '{write: 1'b0, addr: 24'd10,      wdata: 24'h0,      err: 1'b0, rdata: 24'hA1B2C3, lat: 4};
      vecs[2] = '{write: 1'b1, addr: 24'd125,     wdata: 24'h123456, err: 1'b0, rdata: 24'h0,      lat: 4};
      vecs[3] = '{write: 1'b0, addr: 24'd125,     wdata: 24'h0,      err: 1'b0, rdata: 24'h123456, lat: 4};
      vecs[4] = '{write: 1'b0, addr: 24'd126,     wdata: 24'h0,      err: 1'b1, rdata: 24'h0,      lat: 1};
      vecs[5] = '{write: 1'b1, addr: 24'd0,       wdata: 24'hDEADBE, err: 1'b0, rdata: 24'h0,      lat: 4};
      vecs[6] = '{write: 1'b1, addr: 24'hFFFFFE,  wdata: 24'h112233, err: 1'b1, rdata: 24'h0,      lat: 1};
      vecs[7] = '{write: 1'b0, addr: 24'd0,       wdata: 24'h0,      err: 1'b0, rdata: 24'hDEADBE, lat: 4};
      vecs[8] = '{write: 1'b1, addr: 24'd126,     wdata: 24'h445566, err: 1'b1, rdata: 24'h0,      lat: 1};
      vecs[9] = '{write: 1'b0, addr: 24'd125,     wdata: 24'h0,      err: 1'b0, rdata: 24'h123456, lat: 4};

      @(negedge Clock);
      chk("rst_ready", 32'(ReqReady), 32'd1);
      chk("rst_resp", 32'({RespValid, RespError}), 32'd0);
      chk("rst_rdata", 32'(RespReadData), 32'd0);
      chk("rst_strobes", 32'({MemWrite, MemRead}), 32'd0);
      chk("rst_maddr", 32'(MemAddress), 32'd0);
      chk("rst_mwdata", 32'(MemWriteData), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Reset during the second XFER cycle of a store to 20.
      @(negedge Clock);
      ReqValid     = 1'b1;
      ReqWrite     = 1'b1;
      ReqAddress   = 24'd20;
      ReqWriteData = 24'h778899;
      @(posedge Clock);
      #1 ReqValid = 1'b0;
      @(negedge Clock);
      chk("abort_x0_addr", 32'(MemAddress), 32'd20);
      @(negedge Clock);
      chk("abort_x1_addr", 32'(MemAddress), 32'd21);
      Reset = 1'b1;
      #1;
      chk("abort_strobes", 32'({MemWrite, MemRead}), 32'd0);
      chk("abort_maddr", 32'(MemAddress), 32'd0);
      chk("abort_ready", 32'(ReqReady), 32'd1);
      chk("abort_resp", 32'(RespValid), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      rv_seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge Clock);
         if (RespValid) rv_seen++;
      end
      chk("abort_no_resp", 32'(rv_seen), 32'd0);
      // Only byte 20 was written before the abort; 21 and 22 remain zero.
      run_vec('{write: 1'b0, addr: 24'd20, wdata: 24'h0, err: 1'b0, rdata: 24'h770000, lat: 4});

      // Back-to-back loads with ReqValid held high.
      @(negedge Clock);
      ReqValid   = 1'b1;
      ReqWrite   = 1'b0;
      ReqAddress = 24'd10;
      @(posedge Clock);
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clock);
         if (c >= 1 && c <= 4) chk("b2b_not_ready", 32'(ReqReady), 32'd0);
         if (c == 4) begin
            chk("b2b_resp1", 32'(RespValid), 32'd1);
            chk("b2b_data1", 32'(RespReadData), 32'hA1B2C3);
         end
         if (c == 5) chk("b2b_ready5", 32'(ReqReady), 32'd1);
         if (c == 6) begin
            chk("b2b_second_xfer", 32'(MemRead), 32'd1);
            ReqValid = 1'b0;
         end
         if (c == 9) begin
            chk("b2b_resp2", 32'(RespValid), 32'd1);
            chk("b2b_data2", 32'(RespReadData), 32'hA1B2C3);
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
